riscv_fetch: RTL and testbench

Instruction fetch stage of the kana-riscv core. It holds the PC and issues word fetches to instruction memory over a request/grant/response protocol. Returned instructions are buffered with their PC in a 2-entry queue and presented to decode, which feeds the immediate extender, over a valid/ready handshake. Control-flow redirects from execute flush the queue and squash any in-flight response.

---
 rtl/riscv_fetch.sv | 146 ++++++++++++++
 tb/tb_riscv_fetch.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch
// Description : Instruction fetch stage of the kana-riscv core. Holds the PC,
//               issues word fetches over a request/grant/response protocol,
//               buffers returned instructions with their PC in a 2-entry
//               queue and presents them to decode over valid/ready.
//               Redirects from execute flush the queue and squash any
//               in-flight response.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               imem_req/addr     - fetch request and word-aligned address
//               imem_gnt          - request accepted this cycle
//               imem_rvalid/rdata - fetch response
//               redirect/_pc      - control-flow redirect pulse and target
//               fetch_misaligned  - pulse: last redirect target unaligned
//               inst_valid/inst/inst_pc/inst_ready - decode handshake
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch #(
    parameter int                     WORD_LENGTH  = 32,
    parameter logic [WORD_LENGTH-1:0] RESET_VECTOR = {WORD_LENGTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [WORD_LENGTH-1:0] imem_addr,
    input  logic                   imem_gnt,
    input  logic                   imem_rvalid,
    input  logic [WORD_LENGTH-1:0] imem_rdata,
    input  logic                   redirect,
    input  logic [WORD_LENGTH-1:0] redirect_pc,
    output logic                   fetch_misaligned,
    output logic                   inst_valid,
    output logic [WORD_LENGTH-1:0] inst,
    output logic [WORD_LENGTH-1:0] inst_pc,
    input  logic                   inst_ready
);

    localparam logic [WORD_LENGTH-1:0] c_PC_STEP = WORD_LENGTH'(4);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,   // no fetch outstanding
        ST_WAIT = 2'd1,   // one fetch granted, response pending
        ST_DROP = 2'd2    // one fetch outstanding, response to be discarded
    } state_t;

    state_t                 r_state;
    logic [WORD_LENGTH-1:0] r_pc;
    logic [WORD_LENGTH-1:0] r_req_pc;
    logic [WORD_LENGTH-1:0] r_fifo_pc   [2];
    logic [WORD_LENGTH-1:0] r_fifo_inst [2];
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [1:0]             r_count;
    logic                   r_misaligned;

    logic w_grant;
    logic w_push;
    logic w_pop;

    // Only one fetch is ever outstanding, so requesting only while the
    // queue has a free slot guarantees the response always fits.
    assign imem_req  = (r_state == ST_REQ) && (r_count < 2'd2) && !rst;
    assign imem_addr = r_pc;

    assign w_grant = imem_req && imem_gnt;
    assign w_pop   = inst_valid && inst_ready;
    // A response landing in a redirect cycle belongs to the old path.
    assign w_push  = (r_state == ST_WAIT) && imem_rvalid && !redirect;

    assign inst_valid       = (r_count != 2'd0);
    assign inst             = r_fifo_inst[r_rd_ptr];
    assign inst_pc          = r_fifo_pc[r_rd_ptr];
    assign fetch_misaligned = r_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_VECTOR;
            r_req_pc     <= RESET_VECTOR;
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_count      <= 2'd0;
            r_misaligned <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_pc[i]   <= {WORD_LENGTH{1'b0}};
                r_fifo_inst[i] <= {WORD_LENGTH{1'b0}};
            end
        end else begin
            r_misaligned <= redirect && (|redirect_pc[1:0]);

            if (redirect) begin
                // Target is force-aligned; misalignment is only reported.
                r_pc     <= {redirect_pc[WORD_LENGTH-1:2], 2'b00};
                r_count  <= 2'd0;
                r_rd_ptr <= 1'b0;
                r_wr_ptr <= 1'b0;
                case (r_state)
                    // A fetch granted in the redirect cycle is still in
                    // flight and its response must be swallowed.
                    ST_REQ:  r_state <= w_grant ? ST_DROP : ST_REQ;
                    ST_WAIT,
                    ST_DROP: r_state <= imem_rvalid ? ST_REQ : ST_DROP;
                    default: r_state <= ST_REQ;
                endcase
            end else begin
                case (r_state)
                    ST_REQ: begin
                        if (w_grant) begin
                            r_req_pc <= r_pc;
                            r_pc     <= r_pc + c_PC_STEP;
                            r_state  <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (imem_rvalid) begin
                            r_state <= ST_REQ;
                        end
                    end
                    ST_DROP: begin
                        if (imem_rvalid) begin
                            r_state <= ST_REQ;
                        end
                    end
                    default: r_state <= ST_REQ;
                endcase

                if (w_push) begin
                    r_fifo_pc[r_wr_ptr]   <= r_req_pc;
                    r_fifo_inst[r_wr_ptr] <= imem_rdata;
                    r_wr_ptr              <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_fetch
// Description : Directed self-checking bench for riscv_fetch. A small memory
//               model grants every request and answers one cycle later with
//               addr ^ 32'hA5A5_0000; a manual mode lets a scenario drive
//               grant/response by hand. Inputs change on the falling edge,
//               the memory model reacts 1 time unit later, checks sample
//               2 time units after the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch;

    localparam int          W    = 32;
    localparam logic [31:0] RV   = 32'h0000_0100;
    localparam logic [31:0] XORV = 32'hA5A5_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [W-1:0]  imem_rdata = '0;
    logic          redirect = 1'b0;
    logic [W-1:0]  redirect_pc = '0;
    logic          fetch_misaligned;
    logic          inst_valid;
    logic [W-1:0]  inst;
    logic [W-1:0]  inst_pc;
    logic          inst_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // memory model controls
    logic         mem_auto   = 1'b1;
    logic         man_gnt    = 1'b0;
    logic         man_rvalid = 1'b0;
    logic [31:0]  man_rdata  = '0;
    logic         pend       = 1'b0;
    logic [31:0]  pend_addr  = '0;

    riscv_fetch #(
        .WORD_LENGTH (W),
        .RESET_VECTOR(RV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .fetch_misaligned(fetch_misaligned),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_ready      (inst_ready)
    );

    always #5 clk = ~clk;

    // Single-cycle memory: grant now, respond in the following cycle.
    always @(negedge clk) begin
        #1;
        if (mem_auto) begin
            imem_rvalid = pend;
            imem_rdata  = pend_addr ^ XORV;
            imem_gnt    = 1'b1;
            pend        = imem_req;
            pend_addr   = imem_addr;
        end else begin
            imem_gnt    = man_gnt;
            imem_rvalid = man_rvalid;
            imem_rdata  = man_rdata;
            pend        = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Leaves the caller in the first post-reset cycle, just after rst drops.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        mem_auto   = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        n_vec++;
        if ({imem_req, inst_valid, fetch_misaligned} !== 3'b000) begin
            $display("FAIL reset_ctrl: req/valid/misal=%b required 000", {imem_req, inst_valid, fetch_misaligned});
            n_err++;
        end
        n_vec++;
        if ({inst, inst_pc} !== 64'h0) begin
            $display("FAIL reset_data: inst=%h pc=%h required 0/0", inst, inst_pc);
            n_err++;
        end
        @(negedge clk);
        rst = 1'b0;
        #2;
        n_vec++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, RV, 1'b0}) begin
            $display("FAIL first_req: req=%b addr=%h valid=%b required 1 %h 0", imem_req, imem_addr, inst_valid, RV);
            n_err++;
        end
    endtask

    // Continues from the first post-reset cycle with inst_ready high.
    task automatic test_stream();
        logic [31:0] pc;
        for (int k = 0; k < 4; k++) begin
            pc = RV + 32'(4 * k);
            @(negedge clk);
            #2;
            n_vec++;
            if (inst_valid !== 1'b0) begin
                $display("FAIL stream_gap%0d: inst_valid=%b required 0", k, inst_valid);
                n_err++;
            end
            @(negedge clk);
            #2;
            n_vec++;
            if ({inst_valid, inst_pc, inst} !== {1'b1, pc, pc ^ XORV}) begin
                $display("FAIL stream_inst%0d: valid=%b pc=%h inst=%h required 1 %h %h", k, inst_valid, inst_pc, inst, pc, pc ^ XORV);
                n_err++;
            end
            n_vec++;
            if ({imem_req, imem_addr} !== {1'b1, pc + 32'd4}) begin
                $display("FAIL stream_req%0d: req=%b addr=%h required 1 %h", k, imem_req, imem_addr, pc + 32'd4);
                n_err++;
            end
        end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            #2;
            if (c >= 4) begin
                n_vec++;
                if ({imem_req, inst_valid, inst_pc} !== {1'b0, 1'b1, RV}) begin
                    $display("FAIL bp_full%0d: req=%b valid=%b pc=%h required 0 1 %h", c, imem_req, inst_valid, inst_pc, RV);
                    n_err++;
                end
            end
        end
        @(negedge clk);
        inst_ready = 1'b1;
        #2;
        n_vec++;
        if ({inst_valid, inst_pc, inst, imem_req} !== {1'b1, RV, RV ^ XORV, 1'b0}) begin
            $display("FAIL bp_pop0: valid=%b pc=%h inst=%h req=%b required 1 %h %h 0", inst_valid, inst_pc, inst, imem_req, RV, RV ^ XORV);
            n_err++;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if ({inst_valid, inst_pc, imem_req, imem_addr} !== {1'b1, RV + 32'd4, 1'b1, RV + 32'd8}) begin
            $display("FAIL bp_pop1: valid=%b pc=%h req=%b addr=%h required 1 %h 1 %h", inst_valid, inst_pc, imem_req, imem_addr, RV + 32'd4, RV + 32'd8);
            n_err++;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if (inst_valid !== 1'b0) begin
            $display("FAIL bp_empty: inst_valid=%b required 0", inst_valid);
            n_err++;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, RV + 32'd8, (RV + 32'd8) ^ XORV}) begin
            $display("FAIL bp_third: valid=%b pc=%h inst=%h required 1 %h %h", inst_valid, inst_pc, inst, RV + 32'd8, (RV + 32'd8) ^ XORV);
            n_err++;
        end
    endtask

    task automatic test_redirect();
        inst_ready = 1'b1;
        do_reset();
        repeat (4) @(negedge clk);
        #2;
        n_vec++;
        if ({imem_req, imem_addr, inst_pc} !== {1'b1, RV + 32'd8, RV + 32'd4}) begin
            $display("FAIL redir_pre: req=%b addr=%h pc=%h required 1 %h %h", imem_req, imem_addr, inst_pc, RV + 32'd8, RV + 32'd4);
            n_err++;
        end
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect = 1'b0;
        #2;
        n_vec++;
        if ({inst_valid, imem_req, imem_addr, fetch_misaligned} !== {1'b0, 1'b1, 32'h200, 1'b0}) begin
            $display("FAIL redir_next: valid=%b req=%b addr=%h misal=%b required 0 1 00000200 0", inst_valid, imem_req, imem_addr, fetch_misaligned);
            n_err++;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if (inst_valid !== 1'b0) begin
            $display("FAIL redir_squash: inst_valid=%b required 0", inst_valid);
            n_err++;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h200, 32'hA5A5_0200}) begin
            $display("FAIL redir_first: valid=%b pc=%h inst=%h required 1 00000200 a5a50200", inst_valid, inst_pc, inst);
            n_err++;
        end
    endtask

    // Redirect lands while an entry is buffered and a response arrives.
    task automatic test_misaligned();
        inst_ready = 1'b0;
        do_reset();
        repeat (3) @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        #2;
        n_vec++;
        if ({inst_valid, inst_pc, fetch_misaligned} !== {1'b1, RV, 1'b0}) begin
            $display("FAIL misal_pre: valid=%b pc=%h misal=%b required 1 %h 0", inst_valid, inst_pc, fetch_misaligned, RV);
            n_err++;
        end
        @(negedge clk);
        redirect = 1'b0;
        #2;
        n_vec++;
        if ({fetch_misaligned, inst_valid, imem_req, imem_addr} !== {1'b1, 1'b0, 1'b1, 32'h200}) begin
            $display("FAIL misal_pulse: misal=%b valid=%b req=%b addr=%h required 1 0 1 00000200", fetch_misaligned, inst_valid, imem_req, imem_addr);
            n_err++;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if ({fetch_misaligned, inst_valid} !== 2'b00) begin
            $display("FAIL misal_clear: misal=%b valid=%b required 0 0", fetch_misaligned, inst_valid);
            n_err++;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h200, 32'hA5A5_0200}) begin
            $display("FAIL misal_first: valid=%b pc=%h inst=%h required 1 00000200 a5a50200", inst_valid, inst_pc, inst);
            n_err++;
        end
    endtask

    // Redirect in the same cycle as a grant: that response must be dropped.
    task automatic test_redirect_on_grant();
        inst_ready = 1'b1;
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        #2;
        n_vec++;
        if ({imem_req, imem_addr} !== {1'b1, RV}) begin
            $display("FAIL rog_req: req=%b addr=%h required 1 %h", imem_req, imem_addr, RV);
            n_err++;
        end
        @(negedge clk);
        redirect = 1'b0;
        #2;
        n_vec++;
        if ({imem_req, inst_valid} !== 2'b00) begin
            $display("FAIL rog_drop: req=%b valid=%b required 0 0", imem_req, inst_valid);
            n_err++;
        end
        @(negedge clk);
        #2;
        n_vec++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h300, 1'b0}) begin
            $display("FAIL rog_newreq: req=%b addr=%h valid=%b required 1 00000300 0", imem_req, imem_addr, inst_valid);
            n_err++;
        end
        repeat (2) @(negedge clk);
        #2;
        n_vec++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h300, 32'hA5A5_0300}) begin
            $display("FAIL rog_first: valid=%b pc=%h inst=%h required 1 00000300 a5a50300", inst_valid, inst_pc, inst);
            n_err++;
        end
    endtask

    task automatic test_reset_in_wait();
        mem_auto   = 1'b0;
        man_gnt    = 1'b0;
        man_rvalid = 1'b0;
        inst_ready = 1'b1;
        do_reset();
        man_gnt = 1'b1;
        #2;
        n_vec++;
        if ({imem_req, imem_addr} !== {1'b1, RV}) begin
            $display("FAIL riw_req: req=%b addr=%h required 1 %h", imem_req, imem_addr, RV);
            n_err++;
        end
        @(negedge clk);
        rst     = 1'b1;
        man_gnt = 1'b0;
        #2;
        n_vec++;
        if (imem_req !== 1'b0) begin
            $display("FAIL riw_rstreq: imem_req=%b required 0", imem_req);
            n_err++;
        end
        @(negedge clk);
        rst        = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        #2;
        n_vec++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, RV, 1'b0}) begin
            $display("FAIL riw_fresh: req=%b addr=%h valid=%b required 1 %h 0", imem_req, imem_addr, inst_valid, RV);
            n_err++;
        end
        @(negedge clk);
        man_rvalid = 1'b0;
        mem_auto   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            n_vec++;
            if (inst_valid !== 1'b0) begin
                $display("FAIL riw_stale%0d: inst_valid=%b inst=%h required 0", c, inst_valid, inst);
                n_err++;
            end
            @(negedge clk);
        end
        #2;
        n_vec++;
        if ({inst_valid, inst_pc, inst} !== {1'b1, RV, RV ^ XORV}) begin
            $display("FAIL riw_first: valid=%b pc=%h inst=%h required 1 %h %h", inst_valid, inst_pc, inst, RV, RV ^ XORV);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_redirect_on_grant();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
